adder32: RTL and testbench

// - 32-bit two's-complement add/subtract unit with Z/V/N condition flags; the arithmetic slice of the ALU.
// - ALUFN selects add or subtract. Result and flags are registered: one-cycle latency, always-on pipeline.
// - Feeds the ALU result mux and branch-compare logic. Downstream consumers read the flags (Z/V/N).
//

---
 rtl/adder32_pkg.sv | 9 +
 rtl/adder32_if.sv | 15 +
 rtl/adder32_cla4.sv | 31 +++
 rtl/adder32.sv | 63 ++++++
 tb/tb_adder32.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/adder32_pkg.sv
// Shared ALU definitions: operation encodings, datapath width and word type.
package adder32_pkg;
  localparam int DATA_W = 32;

  localparam logic ALUFN_ADD = 1'b0;
  localparam logic ALUFN_SUB = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/adder32_if.sv
// Operand/result bundle between the ALU front end and the add/subtract slice.
interface adder32_if;
  import adder32_pkg::*;

  word_t A;
  word_t B;
  logic  ALUFN;
  word_t sum;
  logic  Z;
  logic  V;
  logic  N;

  modport master (output A, output B, output ALUFN, input sum, input Z, input V, input N);
  modport slave  (input A, input B, input ALUFN, output sum, output Z, output V, output N);
endinterface

// File: rtl/adder32_cla4.sv
// 4-bit carry-lookahead group; exports group generate/propagate for the
// second-level carry chain in the top.
module adder32_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       cout
);
  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign s = pi ^ c;

  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;
  assign cout = g | (p & cin);
endmodule

// File: rtl/adder32.sv
// Registered 32-bit add/subtract slice of the ALU with Z/V/N flags; one-cycle
// latency, new result every cycle.
module adder32
  import adder32_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic      clk,
  input  logic      rst_n,
  adder32_if.slave  bus
);
  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [NGRP:0]    c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_cout;
  logic             cin;
  logic             c_msb_in;
  logic             v_next;

  // Subtract is A + ~B + 1, so the operation bit doubles as carry-in.
  assign cin  = (bus.ALUFN == ALUFN_SUB);
  assign bx   = cin ? ~bus.B : bus.B;
  assign c[0] = cin;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    adder32_cla4 u_cla4 (
      .a    (bus.A[4*i +: 4]),
      .b    (bx[4*i +: 4]),
      .cin  (c[i]),
      .s    (s[4*i +: 4]),
      .g    (grp_g[i]),
      .p    (grp_p[i]),
      .cout (grp_cout[i])
    );
    assign c[i+1] = grp_g[i] | (grp_p[i] & c[i]);
  end

  // The sum bit is a ^ b ^ carry-in, which recovers the carry into the MSB.
  assign c_msb_in = s[WIDTH-1] ^ bus.A[WIDTH-1] ^ bx[WIDTH-1];
  assign v_next   = c_msb_in ^ c[NGRP];

  // Each group's own carry-out must agree with the second-level chain.
  a_grp_carry : assert property (@(posedge clk) disable iff (!rst_n)
    grp_cout == c[NGRP:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum <= '0;
      bus.Z   <= 1'b1;
      bus.V   <= 1'b0;
      bus.N   <= 1'b0;
    end else begin
      bus.sum <= s;
      bus.Z   <= (s == '0);
      bus.V   <= v_next;
      bus.N   <= s[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: stimulus pushes expected results, a monitor
// pops and compares one edge later.
module tb_adder32;
  import adder32_pkg::*;

  typedef struct packed {
    word_t sum;
    logic  z;
    logic  v;
    logic  n;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  adder32_if bus ();

  adder32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  function automatic exp_t model(word_t a, word_t b, logic f);
    exp_t  e;
    word_t bxm;
    word_t sm;
    bxm   = f ? ~b : b;
    sm    = a + bxm + {31'b0, f};
    e.sum = sm;
    e.z   = (sm == 32'h0);
    e.n   = sm[31];
    e.v   = (a[31] == bxm[31]) && (sm[31] != a[31]);
    return e;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input word_t a, input word_t b, input logic f, input exp_t e);
    bus.A     = a;
    bus.B     = b;
    bus.ALUFN = f;
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    n_checks++;
    if ({bus.sum, bus.Z, bus.V, bus.N} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got sum=%h Z=%b V=%b N=%b, expected sum=00000000 Z=1 V=0 N=0",
               name, bus.sum, bus.Z, bus.V, bus.N);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      n_checks++;
      if ({bus.sum, bus.Z, bus.V, bus.N} !== {e.sum, e.z, e.v, e.n}) begin
        n_fail++;
        $display("FAIL vec%0d: got sum=%h Z=%b V=%b N=%b, expected sum=%h Z=%b V=%b N=%b",
                 id, bus.sum, bus.Z, bus.V, bus.N, e.sum, e.z, e.v, e.n);
      end
    end
  end

  initial begin
    bus.A     = '0;
    bus.B     = '0;
    bus.ALUFN = ALUFN_ADD;
    #1 rst_n = 1'b0;
    #2 check_reset("reset_initial");
    repeat (3) @(posedge clk);
    #1 check_reset("reset_hold");

    @(negedge clk);
    rst_n = 1'b1;
    //        A             B             fn         {sum,          z,    v,    n}
    apply(32'h0000_0055, 32'h0000_0033, ALUFN_ADD, {32'h0000_0088, 1'b0, 1'b0, 1'b0});
    apply(32'h0000_0055, 32'h0000_0033, ALUFN_SUB, {32'h0000_0022, 1'b0, 1'b0, 1'b0});
    apply(32'h7FFF_FFFF, 32'h0000_0001, ALUFN_ADD, {32'h8000_0000, 1'b0, 1'b1, 1'b1});
    apply(32'h8000_0000, 32'h0000_0001, ALUFN_SUB, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    apply(32'h0000_0000, 32'h0000_0000, ALUFN_ADD, {32'h0000_0000, 1'b1, 1'b0, 1'b0});
    apply(32'h8000_0000, 32'h0000_0001, ALUFN_ADD, {32'h8000_0001, 1'b0, 1'b0, 1'b1});
    apply(32'hFFFF_FFFF, 32'h0000_0001, ALUFN_ADD, {32'h0000_0000, 1'b1, 1'b0, 1'b0});
    apply(32'h8000_0000, 32'h8000_0000, ALUFN_SUB, {32'h0000_0000, 1'b1, 1'b0, 1'b0});
    apply(32'h0000_0000, 32'h8000_0000, ALUFN_SUB, {32'h8000_0000, 1'b0, 1'b1, 1'b1});
    apply(32'h0000_0005, 32'h0000_0007, ALUFN_SUB, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
    apply(32'h0000_0005, 32'h0000_0007, ALUFN_ADD, {32'h0000_000C, 1'b0, 1'b0, 1'b0});
    apply(32'h1234_5678, 32'h1234_5678, ALUFN_SUB, {32'h0000_0000, 1'b1, 1'b0, 1'b0});

    // Hold a result, then reset between edges with new operands pending.
    bus.A     = 32'h0000_0100;
    bus.B     = 32'h0000_0001;
    bus.ALUFN = ALUFN_ADD;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_midstream");
    repeat (2) @(posedge clk);
    #1 check_reset("reset_midstream_hold");

    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_0100, 32'h0000_0001, ALUFN_ADD, {32'h0000_0101, 1'b0, 1'b0, 1'b0});
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALUFN_ADD, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < 40; i++) begin
      word_t a;
      word_t b;
      logic  f;
      a = $urandom();
      b = $urandom();
      f = logic'($urandom_range(1, 0));
      apply(a, b, f, model(a, b, f));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
